// File: rtl/alu_pkg.sv
// Shared ALU / mul-div definitions.
//   - aluctrl encodings understood by the alu module
//   - md_op_t    : mul/div operation select (matches the 2-bit op port)
//   - md_state_t : muldiv_seq FSM states
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between pipeline control and muldiv_seq.
//   start_valid/start_ready : request handshake, carries op/src_a/src_b
//   result_valid/result_ready : result handshake, carries result
//   busy : sequencer not idle
// master = pipeline side, slave = sequencer side.
interface muldiv_seq_if
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
);
    logic               start_valid;
    logic               start_ready;
    md_op_t             op;
    logic [D_WIDTH-1:0] src_a;
    logic [D_WIDTH-1:0] src_b;
    logic               result_valid;
    logic               result_ready;
    logic [D_WIDTH-1:0] result;
    logic               busy;

    modport master (
        output start_valid, op, src_a, src_b, result_ready,
        input  start_ready, result_valid, result, busy
    );

    modport slave (
        input  start_valid, op, src_a, src_b, result_ready,
        output start_ready, result_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq_alu.sv
// alu: the existing combinational execute-stage ALU.
//   a, b     in  D_WIDTH  operands
//   aluctrl  in  3        ALU_ADD/SUB/AND/OR/SLT (others give 0)
//   y        out D_WIDTH  result
//   eq       out 1        a == b
module alu
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    input  logic [2:0]         aluctrl,
    output logic [D_WIDTH-1:0] y,
    output logic               eq
);
    always_comb begin
        y = '0;
        case (aluctrl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(D_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
    end

    assign eq = (a == b);
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MUL/MULHU/DIVU/REMU, one bit per clock.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_seq_if.slave (request in, result out, busy)
// One shared alu at D_WIDTH+1 bits: ADD for shift-add multiply, SUB for
// restoring divide. The {hi,lo} pair is the product register for multiply
// and {rem,quo} for divide; mcand holds the multiplicand or the divisor.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int              CNT_W = $clog2(D_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(D_WIDTH - 1);

    md_state_t          state;
    md_op_t             op_r;
    logic [CNT_W-1:0]   cnt;
    logic [D_WIDTH-1:0] hi, lo, mcand;

    logic [D_WIDTH:0]   alu_a, alu_b, alu_y, sum;
    logic [2:0]         alu_ctrl;
    logic               alu_eq_unused;
    logic [D_WIDTH-1:0] hi_nxt, lo_nxt;
    logic               is_div;

    assign is_div = (op_r == MD_DIVU) || (op_r == MD_REMU);

    // Divide feeds {rem, next dividend bit}; multiply feeds {0, hi}.
    always_comb begin
        alu_a    = {1'b0, hi};
        alu_ctrl = ALU_ADD;
        if (is_div) begin
            alu_a    = {hi, lo[D_WIDTH-1]};
            alu_ctrl = ALU_SUB;
        end
    end

    assign alu_b = {1'b0, mcand};

    alu #(.D_WIDTH(D_WIDTH + 1)) u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .aluctrl (alu_ctrl),
        .y       (alu_y),
        .eq      (alu_eq_unused)
    );

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        sum    = '0;
        if (is_div) begin
            // Non-negative difference: keep it and shift in quotient bit 1.
            if (!alu_y[D_WIDTH]) begin
                hi_nxt = alu_y[D_WIDTH-1:0];
                lo_nxt = {lo[D_WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = alu_a[D_WIDTH-1:0];
                lo_nxt = {lo[D_WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry bit of the 33-bit sum becomes the new top of hi.
            sum    = lo[0] ? alu_y : {1'b0, hi};
            hi_nxt = sum[D_WIDTH:1];
            lo_nxt = {sum[0], lo[D_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op_r             <= MD_MUL;
            cnt              <= '0;
            hi               <= '0;
            lo               <= '0;
            mcand            <= '0;
            bus.start_ready  <= 1'b1;
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid && bus.start_ready) begin
                        op_r            <= bus.op;
                        cnt             <= '0;
                        hi              <= '0;
                        // Divide: lo = dividend, mcand = divisor.
                        // Multiply: lo = multiplier, mcand = multiplicand.
                        lo              <= bus.op[1] ? bus.src_a : bus.src_b;
                        mcand           <= bus.op[1] ? bus.src_b : bus.src_a;
                        state           <= RUN;
                        bus.start_ready <= 1'b0;
                        bus.busy        <= 1'b1;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state            <= DONE;
                        bus.result_valid <= 1'b1;
                        // MULHU/REMU live in hi, MUL/DIVU in lo.
                        bus.result       <= op_r[0] ? hi_nxt : lo_nxt;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state            <= IDLE;
                        bus.result_valid <= 1'b0;
                        bus.start_ready  <= 1'b1;
                        bus.busy         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, mul/div results, divide by zero,
// result backpressure and mid-run reset.
module tb_muldiv_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    muldiv_seq_if #(.D_WIDTH(32)) bus ();

    muldiv_seq #(.D_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request; returns after the accept edge (+1 time unit).
    task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op          = op;
        bus.src_a       = a;
        bus.src_b       = b;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
    endtask

    // Count edges after the accept edge until result_valid; 32 expected.
    task automatic wait_result(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.result_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'd32);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, bus.result_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, bus.start_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        issue(op, a, b);
        wait_result(tag, n);
        check(tag, bus.result, exp);
        consume(tag);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        bus.start_valid  = 1'b0;
        bus.op           = MD_MUL;
        bus.src_a        = '0;
        bus.src_b        = '0;
        bus.result_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_start_ready",  {31'b0, bus.start_ready},  32'd1);
        check("rst_result_valid", {31'b0, bus.result_valid}, 32'd0);
        check("rst_busy",         {31'b0, bus.busy},         32'd0);
        check("rst_result",       bus.result,                32'd0);

        run_op("mul_7x6",     MD_MUL,   32'd7,        32'd6,        32'd42);
        run_op("mulhu_ff",    MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mul_ff",      MD_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("divu_100_7",  MD_DIVU,  32'd100,      32'd7,        32'd14);
        run_op("remu_100_7",  MD_REMU,  32'd100,      32'd7,        32'd2);
        run_op("divu_msb_1",  MD_DIVU,  32'h80000000, 32'd1,        32'h80000000);
        run_op("divu_5_0",    MD_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF);
        run_op("remu_5_0",    MD_REMU,  32'd5,        32'd0,        32'd5);

        // Backpressure: result held while result_ready is low, and a pending
        // request is not taken until the cycle after the handshake.
        issue(MD_MUL, 32'd12345, 32'd1000);
        wait_result("bp", n);
        held = bus.result;
        check("bp_result", held, 32'd12345000);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op          = MD_MUL;
        bus.src_a       = 32'd11;
        bus.src_b       = 32'd13;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid",  {31'b0, bus.result_valid}, 32'd1);
            check("bp_hold_result", bus.result,                held);
            check("bp_hold_sready", {31'b0, bus.start_ready},  32'd0);
        end
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        check("bp_hs_valid", {31'b0, bus.result_valid}, 32'd0);
        check("bp_hs_busy",  {31'b0, bus.busy},         32'd0);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        check("bp_next_accept", {31'b0, bus.busy}, 32'd1);
        wait_result("bp2", n);
        check("bp2_result", bus.result, 32'd143);
        consume("bp2");

        // Reset in the middle of RUN.
        issue(MD_MUL, 32'hDEADBEEF, 32'h12345678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_start_ready",  {31'b0, bus.start_ready},  32'd1);
        check("midrst_result_valid", {31'b0, bus.result_valid}, 32'd0);
        check("midrst_busy",         {31'b0, bus.busy},         32'd0);
        check("midrst_result",       bus.result,                32'd0);
        run_op("mul_3x3", MD_MUL, 32'd3, 32'd3, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
